multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Control FSM for the multicycle MIPS datapath. It replaces the single-cycle main decoder and ALU decoder for the shared-memory, single-ALU datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives all datapath mux selects and write enables, and counts retired instructions.

Parameters:
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous reset, active low
opcode  input  6  instr[31:26] from instruction register
funct  input  6  instr[5:0] from instruction register
zero  input  1  ALU zero flag
pcEn  output  1  PC register write enable
iord  output  1  memory address select: 0=PC, 1=ALUOut
memWrite  output  1  data memory write
irWrite  output  1  instruction register load
regWrite  output  1  register file write
regdst  output  1  write register: 0=rt, 1=rd
memtoReg  output  1  writeback data: 0=ALUOut, 1=MDR
aluSrcA  output  1  0=PC, 1=regA
aluSrcB  output  2  00=regB, 01=const 4, 10=imm, 11=signImm<<2
immZext  output  1  1=zero-extend imm (andi/ori), else sign-extend
pcSrc  output  2  00=ALUResult, 01=ALUOut, 10=jump target
aluControl  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
illegal  output  1  one-cycle pulse: unsupported opcode/funct
state  output  4  current FSM state (debug)
retired  output  CNT_W  retired-instruction count

Behaviour:
- Reset is synchronous: rst_n sampled low at a rising edge gives state=FETCH and retired=0.
- While rst_n is low, pcEn, memWrite, irWrite, regWrite and illegal are forced to 0 combinationally.
- A reset asserted in any state aborts the instruction. No partial write occurs after that edge.
- Outputs are Moore (decoded from state), with two exceptions:
  - pcEn = pcWrite | (branch & zero).
  - illegal depends on opcode/funct in DECODE.
- Unlisted outputs are 0 in each state.
- State encoding and outputs:
  - FETCH=0: iord=0, aluSrcA=0, aluSrcB=01, aluControl=010, pcSrc=00, irWrite=1, pcWrite=1. Next is DECODE.
  - DECODE=1: aluSrcA=0, aluSrcB=11, aluControl=010 (branch target into ALUOut). Next by opcode:
    - 100011/101011 go to MEMADR.
    - 000000 goes to EXECUTE.
    - 000100 goes to BRANCH.
    - 001000/001100/001101/001010 go to IEXEC.
    - 000010 goes to JUMP.
    - Any other opcode goes to FETCH with illegal=1.
    - R-type with funct not in {100000,100010,100100,100101,101010} goes to FETCH with illegal=1.
  - MEMADR=2: aluSrcA=1, aluSrcB=10, aluControl=010. Next is MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD=3: iord=1. Next is MEMWB.
  - MEMWB=4: regdst=0, memtoReg=1, regWrite=1. Next is FETCH (retire).
  - MEMWRITE=5: iord=1, memWrite=1. Next is FETCH (retire).
  - EXECUTE=6: aluSrcA=1, aluSrcB=00. aluControl by funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111. Next is ALUWB.
  - ALUWB=7: regdst=1, memtoReg=0, regWrite=1. Next is FETCH (retire).
  - BRANCH=8: aluSrcA=1, aluSrcB=00, aluControl=110, pcSrc=01, branch=1. Next is FETCH (retire, whether or not taken).
  - IEXEC=9: aluSrcA=1, aluSrcB=10. aluControl: addi 010, andi 000, ori 001, slti 111. immZext=1 for andi/ori only. Next is IWB.
  - IWB=10: regdst=0, memtoReg=0, regWrite=1. Next is FETCH (retire).
  - JUMP=11: pcSrc=10, pcWrite=1. Next is FETCH (retire).
  - Encodings 12-15 are unreachable. If entered, they go to FETCH with all enables 0.
- Latencies in cycles:
  - lw = 5.
  - sw, R-type, addi/andi/ori/slti = 4.
  - beq = 3.
  - j = 3.
  - Illegal instruction = 2 (no retire).
- opcode and funct are sampled only in DECODE, EXECUTE, MEMADR and IEXEC. The IR is stable after FETCH.
- retired increments by 1 on each transition into FETCH from a terminal state. It wraps modulo 2^CNT_W and never increments on an illegal exit or on reset.
- At most one of memWrite, regWrite or irWrite is asserted in any cycle.

Test Plan:
- Reset: hold rst_n=0 for 2 edges from a mid-instruction state (MEMREAD) → state=0, retired=0, all enables 0 during reset; first post-reset cycle has irWrite=1, pcEn=1.
- lw (opcode 100011) → states 0,1,2,3,4,0. regWrite=1 with memtoReg=1 only in state 4. retired +1 after 5 cycles.
- sw (101011) then R-type sub (000000/100010) → sw: memWrite=1, iord=1 in state 5 only. sub: aluControl=110 in state 6, regWrite=1 with regdst=1 in state 7. retired +2.
- beq (000100), once with zero=1 and once with zero=0 in BRANCH → taken: pcEn=1, pcSrc=01. Not taken: pcEn=0. Both return to FETCH after 3 cycles.
- ori (001101), slti (001010), j (000010) → ori: aluControl=001, immZext=1. slti: aluControl=111, immZext=0. Both write in state 10 with regdst=0. j: pcEn=1, pcSrc=10 in state 11.
- Illegal opcode 111111 and R-type funct 000000; separately, preset retired to 2^16-1 → illegal=1 in DECODE, next state FETCH, no writes, retired unchanged. In the preset run, the next retire wraps retired to 0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/memory/writeback,
// drives every datapath select and enable, and counts retired instructions.
module multicycle_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pcEn,
    output logic             iord,
    output logic             memWrite,
    output logic             irWrite,
    output logic             regWrite,
    output logic             regdst,
    output logic             memtoReg,
    output logic             aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic             immZext,
    output logic [1:0]       pcSrc,
    output logic [2:0]       aluControl,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        IEXEC    = 4'd9,
        IWB      = 4'd10,
        JUMP     = 4'd11
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] retired_q;

    logic pc_write;
    logic branch;
    logic mem_write_raw;
    logic ir_write_raw;
    logic reg_write_raw;
    logic illegal_raw;
    logic retire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d       = FETCH;
        iord          = 1'b0;
        regdst        = 1'b0;
        memtoReg      = 1'b0;
        aluSrcA       = 1'b0;
        aluSrcB       = 2'b00;
        immZext       = 1'b0;
        pcSrc         = 2'b00;
        aluControl    = 3'b000;
        pc_write      = 1'b0;
        branch        = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        retire        = 1'b0;
        case (state_q)
            FETCH: begin
                aluSrcB      = 2'b01;
                aluControl   = 3'b010;
                ir_write_raw = 1'b1;
                pc_write     = 1'b1;
                state_d      = DECODE;
            end
            DECODE: begin
                // ALU precomputes the branch target into ALUOut while the opcode is decoded
                aluSrcB    = 2'b11;
                aluControl = 3'b010;
                case (opcode)
                    6'b100011, 6'b101011: state_d = MEMADR;
                    6'b000000: begin
                        case (funct)
                            6'b100000, 6'b100010, 6'b100100,
                            6'b100101, 6'b101010: state_d = EXECUTE;
                            default:              illegal_raw = 1'b1;
                        endcase
                    end
                    6'b000100:                               state_d = BRANCH;
                    6'b001000, 6'b001100, 6'b001101, 6'b001010: state_d = IEXEC;
                    6'b000010:                               state_d = JUMP;
                    default:                                 illegal_raw = 1'b1;
                endcase
            end
            MEMADR: begin
                aluSrcA    = 1'b1;
                aluSrcB    = 2'b10;
                aluControl = 3'b010;
                state_d    = (opcode == 6'b100011) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                iord    = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                memtoReg      = 1'b1;
                reg_write_raw = 1'b1;
                retire        = 1'b1;
            end
            MEMWRITE: begin
                iord          = 1'b1;
                mem_write_raw = 1'b1;
                retire        = 1'b1;
            end
            EXECUTE: begin
                aluSrcA = 1'b1;
                case (funct)
                    6'b100010: aluControl = 3'b110;
                    6'b100100: aluControl = 3'b000;
                    6'b100101: aluControl = 3'b001;
                    6'b101010: aluControl = 3'b111;
                    default:   aluControl = 3'b010;
                endcase
                state_d = ALUWB;
            end
            ALUWB: begin
                regdst        = 1'b1;
                reg_write_raw = 1'b1;
                retire        = 1'b1;
            end
            BRANCH: begin
                aluSrcA    = 1'b1;
                aluControl = 3'b110;
                pcSrc      = 2'b01;
                branch     = 1'b1;
                retire     = 1'b1;
            end
            IEXEC: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                case (opcode)
                    6'b001100: begin aluControl = 3'b000; immZext = 1'b1; end
                    6'b001101: begin aluControl = 3'b001; immZext = 1'b1; end
                    6'b001010: aluControl = 3'b111;
                    default:   aluControl = 3'b010;
                endcase
                state_d = IWB;
            end
            IWB: begin
                reg_write_raw = 1'b1;
                retire        = 1'b1;
            end
            JUMP: begin
                pcSrc    = 2'b10;
                pc_write = 1'b1;
                retire   = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // Enables are gated by reset so an aborted instruction can never write anything
    assign pcEn     = rst_n & (pc_write | (branch & zero));
    assign memWrite = rst_n & mem_write_raw;
    assign irWrite  = rst_n & ir_write_raw;
    assign regWrite = rst_n & reg_write_raw;
    assign illegal  = rst_n & illegal_raw;
    assign state    = state_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller: one task per instruction class,
// expected states and control values written out by hand.
module tb_multicycle_controller;

    logic        clk;
    logic        rst_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        pcEn, iord, memWrite, irWrite, regWrite, regdst, memtoReg, aluSrcA;
    logic [1:0]  aluSrcB;
    logic        immZext;
    logic [1:0]  pcSrc;
    logic [2:0]  aluControl;
    logic        illegal;
    logic [3:0]  state;
    logic [15:0] retired;

    int          tests;
    int          errors;
    logic [15:0] exp_retired;

    multicycle_controller #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .pcEn(pcEn), .iord(iord), .memWrite(memWrite), .irWrite(irWrite),
        .regWrite(regWrite), .regdst(regdst), .memtoReg(memtoReg), .aluSrcA(aluSrcA),
        .aluSrcB(aluSrcB), .immZext(immZext), .pcSrc(pcSrc), .aluControl(aluControl),
        .illegal(illegal), .state(state), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; opcode = 6'b000000; funct = 6'b100000; zero = 1'b0;
        tick();
        tick();
        tests++; if (state !== 4'd0) begin errors++; $display("[TB] FAIL reset_state got=%0d exp=0", state); end
        tests++; if (retired !== 16'd0) begin errors++; $display("[TB] FAIL reset_retired got=%0d exp=0", retired); end
        tests++; if ({pcEn, memWrite, irWrite, regWrite, illegal} !== 5'b0) begin errors++;
            $display("[TB] FAIL reset_enables got=%b exp=00000", {pcEn, memWrite, irWrite, regWrite, illegal}); end
        rst_n = 1'b1;
        #1;
        tests++; if ({irWrite, pcEn} !== 2'b11) begin errors++; $display("[TB] FAIL post_reset_fetch irWrite,pcEn got=%b exp=11", {irWrite, pcEn}); end
        tests++; if ({aluSrcB, aluControl} !== 5'b01010) begin errors++; $display("[TB] FAIL fetch_alu got=%b exp=01010", {aluSrcB, aluControl}); end
        exp_retired = 16'd0;
    endtask

    task automatic test_lw();
        logic [3:0] seq [5];
        seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        opcode = 6'b100011;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++; if (state !== seq[i]) begin errors++; $display("[TB] FAIL lw_state step%0d got=%0d exp=%0d", i, state, seq[i]); end
            tests++; if ({regWrite, memtoReg} !== ((seq[i] == 4'd4) ? 2'b11 : 2'b00)) begin errors++;
                $display("[TB] FAIL lw_write step%0d got=%b", i, {regWrite, memtoReg}); end
            if (seq[i] == 4'd1) begin
                tests++; if (illegal !== 1'b0) begin errors++; $display("[TB] FAIL lw_illegal got=%b exp=0", illegal); end
                tests++; if (aluSrcB !== 2'b11) begin errors++; $display("[TB] FAIL decode_srcb got=%b exp=11", aluSrcB); end
            end
            if (seq[i] == 4'd3) begin
                tests++; if (iord !== 1'b1) begin errors++; $display("[TB] FAIL lw_iord got=%b exp=1", iord); end
            end
        end
        exp_retired++;
        tests++; if (retired !== exp_retired) begin errors++; $display("[TB] FAIL lw_retired got=%0d exp=%0d", retired, exp_retired); end
    endtask

    task automatic test_sw_sub();
        opcode = 6'b101011;
        tick();
        tick();
        tests++; if ({state, aluSrcA, aluSrcB} !== {4'd2, 1'b1, 2'b10}) begin errors++;
            $display("[TB] FAIL sw_memadr got=%b exp=0010110", {state, aluSrcA, aluSrcB}); end
        tests++; if ({memWrite, iord} !== 2'b00) begin errors++; $display("[TB] FAIL sw_early_write got=%b exp=00", {memWrite, iord}); end
        tick();
        tests++; if ({state, memWrite, iord, regWrite} !== {4'd5, 3'b110}) begin errors++;
            $display("[TB] FAIL sw_memwrite got=%b exp=0101110", {state, memWrite, iord, regWrite}); end
        tick();
        tests++; if ({state, memWrite} !== {4'd0, 1'b0}) begin errors++; $display("[TB] FAIL sw_return got=%b exp=00000", {state, memWrite}); end
        opcode = 6'b000000; funct = 6'b100010;
        tick();
        tick();
        tests++; if ({state, aluControl, aluSrcA, aluSrcB} !== {4'd6, 3'b110, 1'b1, 2'b00}) begin errors++;
            $display("[TB] FAIL sub_execute got=%b exp=0110110100", {state, aluControl, aluSrcA, aluSrcB}); end
        tick();
        tests++; if ({state, regWrite, regdst, memtoReg} !== {4'd7, 3'b110}) begin errors++;
            $display("[TB] FAIL sub_aluwb got=%b exp=0111110", {state, regWrite, regdst, memtoReg}); end
        tick();
        exp_retired += 16'd2;
        tests++; if ({state, retired} !== {4'd0, exp_retired}) begin errors++;
            $display("[TB] FAIL sw_sub_retired state=%0d retired=%0d exp_retired=%0d", state, retired, exp_retired); end
    endtask

    task automatic test_beq();
        for (int t = 1; t >= 0; t--) begin
            opcode = 6'b000100; zero = 1'b0;
            tick();
            tick();
            zero = t[0];
            #1;
            tests++; if ({state, pcEn, pcSrc} !== {4'd8, t[0], 2'b01}) begin errors++;
                $display("[TB] FAIL beq_branch zero=%0d got=%b exp=%b", t, {state, pcEn, pcSrc}, {4'd8, t[0], 2'b01}); end
            tests++; if (aluControl !== 3'b110) begin errors++; $display("[TB] FAIL beq_alu got=%b exp=110", aluControl); end
            tick();
            exp_retired++;
            tests++; if ({state, retired} !== {4'd0, exp_retired}) begin errors++;
                $display("[TB] FAIL beq_return zero=%0d state=%0d retired=%0d exp_retired=%0d", t, state, retired, exp_retired); end
        end
        zero = 1'b0;
    endtask

    task automatic test_imm_jump();
        logic [5:0] ops [2];
        logic [2:0] alu [2];
        ops = '{6'b001101, 6'b001010};
        alu = '{3'b001, 3'b111};
        for (int i = 0; i < 2; i++) begin
            opcode = ops[i];
            tick();
            tick();
            tests++; if ({state, aluControl, immZext, aluSrcB} !== {4'd9, alu[i], (i == 0), 2'b10}) begin errors++;
                $display("[TB] FAIL imm_iexec op=%b got=%b", ops[i], {state, aluControl, immZext, aluSrcB}); end
            tick();
            tests++; if ({state, regWrite, regdst, memtoReg} !== {4'd10, 3'b100}) begin errors++;
                $display("[TB] FAIL imm_iwb op=%b got=%b exp=1010100", ops[i], {state, regWrite, regdst, memtoReg}); end
            tick();
            exp_retired++;
        end
        opcode = 6'b000010;
        tick();
        tick();
        tests++; if ({state, pcEn, pcSrc} !== {4'd11, 1'b1, 2'b10}) begin errors++;
            $display("[TB] FAIL j_jump got=%b exp=1011110", {state, pcEn, pcSrc}); end
        tick();
        exp_retired++;
        tests++; if ({state, retired} !== {4'd0, exp_retired}) begin errors++;
            $display("[TB] FAIL imm_j_retired state=%0d retired=%0d exp_retired=%0d", state, retired, exp_retired); end
    endtask

    task automatic test_illegal();
        logic [11:0] cases [2];
        cases = '{{6'b111111, 6'b100000}, {6'b000000, 6'b000000}};
        for (int i = 0; i < 2; i++) begin
            {opcode, funct} = cases[i];
            tick();
            tests++; if ({state, illegal} !== {4'd1, 1'b1}) begin errors++;
                $display("[TB] FAIL illegal_decode case%0d got=%b exp=00011", i, {state, illegal}); end
            tests++; if ({memWrite, regWrite, irWrite, pcEn} !== 4'b0) begin errors++;
                $display("[TB] FAIL illegal_writes case%0d got=%b exp=0000", i, {memWrite, regWrite, irWrite, pcEn}); end
            tick();
            tests++; if ({state, illegal, retired} !== {4'd0, 1'b0, exp_retired}) begin errors++;
                $display("[TB] FAIL illegal_exit case%0d state=%0d illegal=%b retired=%0d exp_retired=%0d", i, state, illegal, retired, exp_retired); end
        end
    endtask

    task automatic test_wrap();
        force dut.retired_q = 16'hFFFF;
        #1;
        release dut.retired_q;
        exp_retired = 16'hFFFF;
        opcode = 6'b111111;
        tick();
        tick();
        tests++; if ({state, retired} !== {4'd0, exp_retired}) begin errors++;
            $display("[TB] FAIL wrap_illegal state=%0d retired=%0d exp_retired=%0d", state, retired, exp_retired); end
        opcode = 6'b000010;
        tick();
        tick();
        tick();
        exp_retired++;
        tests++; if ({state, retired} !== {4'd0, 16'd0}) begin errors++;
            $display("[TB] FAIL wrap_retired state=%0d retired=%0d exp_retired=%0d", state, retired, exp_retired); end
    endtask

    task automatic test_reset_mid();
        opcode = 6'b100011;
        tick();
        tick();
        tick();
        tests++; if (state !== 4'd3) begin errors++; $display("[TB] FAIL mid_setup state=%0d exp=3", state); end
        rst_n = 1'b0;
        tick();
        tests++; if ({state, retired} !== {4'd0, 16'd0}) begin errors++;
            $display("[TB] FAIL mid_reset state=%0d retired=%0d exp=0,0", state, retired); end
        tests++; if ({pcEn, memWrite, irWrite, regWrite, illegal} !== 5'b0) begin errors++;
            $display("[TB] FAIL mid_reset_enables got=%b exp=00000", {pcEn, memWrite, irWrite, regWrite, illegal}); end
        tick();
        tests++; if ({state, retired, regWrite} !== {4'd0, 16'd0, 1'b0}) begin errors++;
            $display("[TB] FAIL mid_reset_hold state=%0d retired=%0d regWrite=%b", state, retired, regWrite); end
        rst_n = 1'b1;
        #1;
        tests++; if ({irWrite, pcEn} !== 2'b11) begin errors++; $display("[TB] FAIL mid_post_reset got=%b exp=11", {irWrite, pcEn}); end
    endtask

    initial begin
        tests = 0;
        errors = 0;
        test_reset();
        test_lw();
        test_sw_sub();
        test_beq();
        test_imm_jump();
        test_illegal();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
